// File: rtl/prio_pkg.sv
// Shared definitions for the priority/round-robin encoder: arbitration mode
// constants and the width helper used to size index ports.
package prio_pkg;

  localparam logic PRIO_FIXED = 1'b0;
  localparam logic PRIO_RR    = 1'b1;

  // Ceiling log2; returns 0 for v <= 1, so callers clamp to a minimum width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational selector. Fixed mode returns the highest set index of c.
// Round-robin mode searches downward from p-1, wrapping from 0 to n-1, and
// visits p itself last.
module prio_pick
  import prio_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] c,
  input  logic [W-1:0] p,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan candidates so that the last hit assigned is the preferred one.
  always_comb begin
    int j;
    idx = '0;
    any = |c;
    j   = 0;
    if (mode == PRIO_RR) begin
      // Largest offset first, so offset 1 (index p-1) overrides everything.
      for (int off = N; off >= 1; off--) begin
        j = (int'(p) + N - off) % N;
        if (c[j]) idx = j[W-1:0];
      end
    end else begin
      // Ascending scan: the highest set index is written last.
      for (int k = 0; k < N; k++) begin
        j = k;
        if (c[k]) idx = j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/prio_encode_rr.sv
// Registered priority encoder with accept handshake. Requests are captured
// into pend until their grant is acknowledged; a new grant is chosen whenever
// the output is idle or the current grant is being accepted.
module prio_encode_rr
  import prio_pkg::*;
#(
  parameter int N  = 8,
  parameter int RR = 0,
  localparam int W = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] I,
  input  logic         ack,
  output logic [W-1:0] Y,
  output logic         en,
  output logic [N-1:0] grant,
  output logic [N-1:0] pend
);

  localparam logic MODE = (RR != 0) ? PRIO_RR : PRIO_FIXED;

  logic         hs;
  logic [N-1:0] y_oh;
  logic [N-1:0] cand;
  logic [N-1:0] pend_nxt;
  logic [W-1:0] ptr;
  logic [W-1:0] pick_idx;
  logic         pick_any;

  // Handshake qualifiers, candidate set and next pending vector.
  always_comb begin
    hs   = en & ack;
    y_oh = {{(N-1){1'b0}}, 1'b1} << Y;
    // The just-accepted index never competes on its own handshake edge.
    cand = (pend | I) & ~(hs ? y_oh : '0);
    // A request arriving on the acknowledged line re-pends it.
    pend_nxt = (pend | I) & ~(hs ? (y_oh & ~I) : '0);
    grant    = en ? y_oh : '0;
  end

  prio_pick #(
    .N(N),
    .W(W)
  ) u_pick (
    .c   (cand),
    .p   (ptr),
    .mode(MODE),
    .idx (pick_idx),
    .any (pick_any)
  );

  // All state: pending vector, presented index/valid and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      Y    <= '0;
      en   <= 1'b0;
      ptr  <= '0;
    end else begin
      pend <= pend_nxt;
      if (hs) ptr <= Y;
      if (!en || hs) begin
        if (pick_any) begin
          en <= 1'b1;
          Y  <= pick_idx;
        end else begin
          en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_encode_rr.sv
// Bench for prio_encode_rr: three instances (N=4 fixed, N=4 round-robin,
// N=8 round-robin) compared every cycle against a rule-level model, plus a
// vector table and directed multi-cycle sequences.
module tb_prio_encode_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i0, i1;
  logic [7:0] i2;
  logic       ack0, ack1, ack2;
  logic [1:0] y0, y1;
  logic [2:0] y2;
  logic       en0, en1, en2;
  logic [3:0] g0, g1, p0, p1;
  logic [7:0] g2, p2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_encode_rr #(.N(4), .RR(0)) d0 (.clk(clk), .rst(rst), .I(i0), .ack(ack0),
                                      .Y(y0), .en(en0), .grant(g0), .pend(p0));
  prio_encode_rr #(.N(4), .RR(1)) d1 (.clk(clk), .rst(rst), .I(i1), .ack(ack1),
                                      .Y(y1), .en(en1), .grant(g1), .pend(p1));
  prio_encode_rr #(.N(8), .RR(1)) d2 (.clk(clk), .rst(rst), .I(i2), .ack(ack2),
                                      .Y(y2), .en(en2), .grant(g2), .pend(p2));

  typedef struct {
    bit        en;
    int        y;
    bit [31:0] pend;
    int        p;
  } mstate_t;

  mstate_t m0, m1, m2;

  function automatic mstate_t mreset();
    mstate_t s;
    s.en = 1'b0; s.y = 0; s.pend = '0; s.p = 0;
    return s;
  endfunction

  // Highest set index, or round-robin search starting just below p.
  function automatic int mpick(bit [31:0] c, int n, int rr, int p);
    if (rr == 0) begin
      for (int k = n - 1; k >= 0; k--) if (c[k]) return k;
      return -1;
    end
    for (int s = 1; s <= n; s++) begin
      int k;
      k = (p - s + n) % n;
      if (c[k]) return k;
    end
    return -1;
  endfunction

  function automatic mstate_t mstep(mstate_t s, bit [31:0] req, bit ack, int n, int rr);
    mstate_t   ns;
    bit        hs;
    bit [31:0] c;
    int        k;
    ns = s;
    hs = s.en && ack;
    ns.pend = s.pend | req;
    if (hs && !req[s.y]) ns.pend[s.y] = 1'b0;
    if (hs) ns.p = s.y;
    if (!s.en || hs) begin
      c = s.pend | req;
      if (hs) c[s.y] = 1'b0;
      k = mpick(c, n, rr, s.p);
      if (k < 0) ns.en = 1'b0;
      else begin
        ns.en = 1'b1;
        ns.y  = k;
      end
    end
    return ns;
  endfunction

  function automatic bit [31:0] mgrant(mstate_t s);
    return s.en ? (32'd1 << s.y) : 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("d0.en",    32'(en0), 32'(m0.en));
    chk("d0.y",     32'(y0),  32'(m0.y));
    chk("d0.pend",  32'(p0),  m0.pend);
    chk("d0.grant", 32'(g0),  mgrant(m0));
    chk("d1.en",    32'(en1), 32'(m1.en));
    chk("d1.y",     32'(y1),  32'(m1.y));
    chk("d1.pend",  32'(p1),  m1.pend);
    chk("d1.grant", 32'(g1),  mgrant(m1));
    chk("d2.en",    32'(en2), 32'(m2.en));
    chk("d2.y",     32'(y2),  32'(m2.y));
    chk("d2.pend",  32'(p2),  m2.pend);
    chk("d2.grant", 32'(g2),  mgrant(m2));
  endtask

  task automatic cycle();
    @(posedge clk);
    m0 = mstep(m0, 32'(i0), ack0, 4, 0);
    m1 = mstep(m1, 32'(i1), ack1, 4, 1);
    m2 = mstep(m2, 32'(i2), ack2, 8, 1);
    #1;
    cmp_all();
  endtask

  task automatic idle_inputs();
    i0 = '0; i1 = '0; i2 = '0;
    ack0 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;
  endtask

  // Asynchronous reset pulse between edges; called 1 time unit after an edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    m0 = mreset(); m1 = mreset(); m2 = mreset();
    #1;
    chk("rst_async.en1",   32'(en1), 32'd0);
    chk("rst_async.y1",    32'(y1),  32'd0);
    chk("rst_async.pend1", 32'(p1),  32'd0);
    chk("rst_async.grant1",32'(g1),  32'd0);
    cmp_all();
    #2 rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] i;
    logic       ack;
    logic       en;
    int         y;
    logic [3:0] pend;
  } vec_t;

  vec_t tbl[17];
  int   exp_rr4[6];
  int   exp_rr8[4];

  initial begin
    tbl[0]  = '{4'b0110, 1'b1, 1'b1, 2, 4'b0110};
    tbl[1]  = '{4'b0000, 1'b1, 1'b1, 1, 4'b0010};
    tbl[2]  = '{4'b0000, 1'b1, 1'b0, 1, 4'b0000};
    tbl[3]  = '{4'b0101, 1'b0, 1'b1, 2, 4'b0101};
    tbl[4]  = '{4'b0101, 1'b0, 1'b1, 2, 4'b0101};
    tbl[5]  = '{4'b0101, 1'b0, 1'b1, 2, 4'b0101};
    tbl[6]  = '{4'b1000, 1'b0, 1'b1, 2, 4'b1101};
    tbl[7]  = '{4'b0000, 1'b1, 1'b1, 3, 4'b1001};
    tbl[8]  = '{4'b0000, 1'b1, 1'b1, 0, 4'b0001};
    tbl[9]  = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000};
    tbl[10] = '{4'b0001, 1'b0, 1'b1, 0, 4'b0001};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000};
    tbl[12] = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000};
    tbl[13] = '{4'b0010, 1'b0, 1'b1, 1, 4'b0010};
    tbl[14] = '{4'b0010, 1'b1, 1'b0, 1, 4'b0010};
    tbl[15] = '{4'b0000, 1'b0, 1'b1, 1, 4'b0010};
    tbl[16] = '{4'b0000, 1'b1, 1'b0, 1, 4'b0000};
    exp_rr4 = '{3, 2, 1, 0, 3, 2};
    exp_rr8 = '{7, 0, 7, 0};

    rst = 1'b1;
    idle_inputs();
    m0 = mreset(); m1 = mreset(); m2 = mreset();
    #3;
    chk("reset.en0",   32'(en0), 32'd0);
    chk("reset.y0",    32'(y0),  32'd0);
    chk("reset.pend2", 32'(p2),  32'd0);
    chk("reset.grant2",32'(g2),  32'd0);
    cmp_all();
    #3 rst = 1'b0;

    // Fixed-priority vectors on the N=4 instance.
    for (int r = 0; r < 17; r++) begin
      i0   = tbl[r].i;
      ack0 = tbl[r].ack;
      cycle();
      chk($sformatf("tbl[%0d].en", r),   32'(en0), 32'(tbl[r].en));
      chk($sformatf("tbl[%0d].y", r),    32'(y0),  32'(tbl[r].y));
      chk($sformatf("tbl[%0d].pend", r), 32'(p0),  32'(tbl[r].pend));
      chk($sformatf("tbl[%0d].grant", r), 32'(g0),
          tbl[r].en ? (32'd1 << tbl[r].y) : 32'd0);
    end
    idle_inputs();

    // Round-robin rotation with all four sources held.
    do_reset();
    i1 = 4'hF; ack1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk($sformatf("rr4_seq[%0d].en", k), 32'(en1), 32'd1);
      chk($sformatf("rr4_seq[%0d].y", k),  32'(y1),  32'(exp_rr4[k]));
    end
    idle_inputs();

    // Wrap between the two extreme sources with the pointer starting at 0.
    do_reset();
    i2 = 8'h81; ack2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("rr8_wrap[%0d].y", k), 32'(y2), 32'(exp_rr8[k]));
    end
    idle_inputs();

    // Reset mid-transaction, then a fresh request on the first edge after.
    do_reset();
    i1 = 4'b1010; ack1 = 1'b0;
    cycle();
    chk("midrst.pre.en",   32'(en1), 32'd1);
    chk("midrst.pre.y",    32'(y1),  32'd3);
    chk("midrst.pre.pend", 32'(p1),  32'hA);
    i1 = 4'b0000;
    do_reset();
    i1 = 4'b0100;
    cycle();
    chk("midrst.post.en",   32'(en1), 32'd1);
    chk("midrst.post.y",    32'(y1),  32'd2);
    chk("midrst.post.pend", 32'(p1),  32'h4);
    idle_inputs();

    // Randomised traffic on all three instances against the model.
    for (int n = 0; n < 800; n++) begin
      i0   = 4'($urandom & $urandom);
      i1   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom & $urandom);
      i2   = 8'($urandom & $urandom & $urandom);
      ack0 = ($urandom_range(0, 9) < 6);
      ack1 = ($urandom_range(0, 9) < 5);
      ack2 = ($urandom_range(0, 9) < 7);
      cycle();
    end

    // Drain: with requests stopped and ack held, everything must be granted.
    idle_inputs();
    ack0 = 1'b1; ack1 = 1'b1; ack2 = 1'b1;
    for (int n = 0; n < 20; n++) cycle();
    chk("drain.pend0", 32'(p0),  32'd0);
    chk("drain.pend1", 32'(p1),  32'd0);
    chk("drain.pend2", 32'(p2),  32'd0);
    chk("drain.en2",   32'(en2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
